// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH = 1024;

    typedef enum logic {
        P_PRIO  = 1'b0,
        D_FORCE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// rtl/dmem_rsp_reg.sv - per-port registered load response (rvalid/rdata/err)
module dmem_rsp_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gnt,
    input  logic        we,
    input  logic        in_range,
    input  logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rvalid_d = gnt & ~we;
        err_d    = gnt & ~in_range;
        rdata_d  = rdata_q;
        // Out-of-range loads return zero rather than whatever the memory aliases to.
        if (gnt && !we) begin
            rdata_d = in_range ? mem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with P priority and D starvation guard
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = DMEM_DEPTH,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic        p_gnt,
    output logic        p_stall,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    output logic        p_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         p_req_s, d_req_s, gnt_req;
    logic             gnt_in_range;

    assign p_req_s = '{we: p_we, addr: p_addr, wdata: p_wdata};
    assign d_req_s = '{we: d_we, addr: d_addr, wdata: d_wdata};

    // Grants are forced low in reset so a store in flight cannot reach the memory.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (state_q == D_FORCE) begin
                d_gnt = d_req;
                p_gnt = p_req & ~d_req;
            end else begin
                p_gnt = p_req;
                d_gnt = d_req & ~p_req;
            end
        end
    end

    assign p_stall = p_req & ~p_gnt;

    always_comb begin
        gnt_req = '0;
        if (p_gnt) begin
            gnt_req = p_req_s;
        end else if (d_gnt) begin
            gnt_req = d_req_s;
        end
    end

    assign gnt_in_range = addr_in_range(gnt_req.addr, DEPTH);
    assign mem_addr     = gnt_req.addr;
    assign mem_wdata    = gnt_req.wdata;
    assign mem_we       = gnt_req.we & gnt_in_range;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (!d_req || d_gnt) begin
            cnt_d = '0;
        end else if (cnt_q < STARVE_LIM) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            P_PRIO:  if (cnt_d == STARVE_LIM) state_d = D_FORCE;
            D_FORCE: if (d_gnt || !d_req) state_d = P_PRIO;
            default: state_d = P_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P_PRIO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    dmem_rsp_reg u_p_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (p_gnt),
        .we        (p_we),
        .in_range  (gnt_in_range),
        .mem_rdata (mem_rdata),
        .rvalid    (p_rvalid),
        .rdata     (p_rdata),
        .err       (p_err)
    );

    dmem_rsp_reg u_d_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (d_gnt),
        .we        (d_we),
        .in_range  (gnt_in_range),
        .mem_rdata (mem_rdata),
        .rvalid    (d_rvalid),
        .rdata     (d_rdata),
        .err       (d_err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk, rst_n, preload;
    logic        p_req, p_we, p_gnt, p_stall, p_rvalid, p_err;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [31:0] mem [0:1023];
    int          n_cmp, n_fail;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory aliases addresses modulo 1024, so an unsuppressed out-of-range store or read is visible.
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i == 6) ? 32'd6000 : 32'(i);
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic idle();
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        p_req = 1; d_req = 1; #1;
        n_cmp++; if (p_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_p_gnt: got %0h want 0", p_gnt); end
        n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d_gnt: got %0h want 0", d_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %0h want 0", mem_we); end
        n_cmp++; if ({p_rvalid, p_err, d_rvalid, d_err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {p_rvalid, p_err, d_rvalid, d_err}); end
        n_cmp++; if ({p_rdata, d_rdata} !== 64'd0) begin n_fail++; $display("FAIL rst_rdata: got %0h/%0h want 0/0", p_rdata, d_rdata); end
        @(negedge clk); rst_n = 1; idle(); #1;
        n_cmp++; if (dut.cnt_q !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt_q); end
    endtask

    task automatic test_p_store_load();
        @(negedge clk); p_req = 1; p_we = 1; p_addr = 5; p_wdata = 32'h1234; #1;
        n_cmp++; if (p_gnt !== 1'b1) begin n_fail++; $display("FAIL sl_st_gnt: got %0h want 1", p_gnt); end
        n_cmp++; if (p_stall !== 1'b0) begin n_fail++; $display("FAIL sl_st_stall: got %0h want 0", p_stall); end
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sl_st_we: got %0h want 1", mem_we); end
        n_cmp++; if (mem_addr !== 32'd5) begin n_fail++; $display("FAIL sl_st_addr: got %0h want 5", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL sl_st_wdata: got %0h want 1234", mem_wdata); end
        @(negedge clk); p_we = 0; #1;
        n_cmp++; if (p_gnt !== 1'b1) begin n_fail++; $display("FAIL sl_ld_gnt: got %0h want 1", p_gnt); end
        n_cmp++; if (p_stall !== 1'b0) begin n_fail++; $display("FAIL sl_ld_stall: got %0h want 0", p_stall); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL sl_ld_we: got %0h want 0", mem_we); end
        n_cmp++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL sl_st_rvalid: got %0h want 0", p_rvalid); end
        @(negedge clk); p_req = 0; #1;
        n_cmp++; if (p_rvalid !== 1'b1) begin n_fail++; $display("FAIL sl_rvalid: got %0h want 1", p_rvalid); end
        n_cmp++; if (p_rdata !== 32'h1234) begin n_fail++; $display("FAIL sl_rdata: got %0h want 1234", p_rdata); end
        n_cmp++; if (p_err !== 1'b0) begin n_fail++; $display("FAIL sl_err: got %0h want 0", p_err); end
        @(negedge clk); #1;
        n_cmp++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL sl_rvalid_drop: got %0h want 0", p_rvalid); end
        n_cmp++; if (p_rdata !== 32'h1234) begin n_fail++; $display("FAIL sl_rdata_hold: got %0h want 1234", p_rdata); end
    endtask

    task automatic test_starvation();
        logic exp_d;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            p_req = 1; p_we = 0; p_addr = 10; d_req = 1; d_we = 0; d_addr = 20; #1;
            exp_d = (k % 9 == 8);
            n_cmp++; if (d_gnt !== exp_d) begin n_fail++; $display("FAIL sv_d_gnt[%0d]: got %0h want %0h", k, d_gnt, exp_d); end
            n_cmp++; if (p_gnt !== !exp_d) begin n_fail++; $display("FAIL sv_p_gnt[%0d]: got %0h want %0h", k, p_gnt, !exp_d); end
            n_cmp++; if (p_stall !== exp_d) begin n_fail++; $display("FAIL sv_stall[%0d]: got %0h want %0h", k, p_stall, exp_d); end
            n_cmp++; if (d_rvalid !== (k % 9 == 0 && k > 0)) begin n_fail++; $display("FAIL sv_d_rvalid[%0d]: got %0h", k, d_rvalid); end
            n_cmp++; if (p_rvalid !== (k > 0 && (k - 1) % 9 != 8)) begin n_fail++; $display("FAIL sv_p_rvalid[%0d]: got %0h", k, p_rvalid); end
            if (k == 9) begin
                n_cmp++; if (d_rdata !== 32'd20) begin n_fail++; $display("FAIL sv_d_rdata: got %0h want 14", d_rdata); end
            end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_d_load();
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 6; #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL dl_gnt: got %0h want 1", d_gnt); end
        n_cmp++; if (p_gnt !== 1'b0) begin n_fail++; $display("FAIL dl_p_gnt: got %0h want 0", p_gnt); end
        n_cmp++; if (mem_addr !== 32'd6) begin n_fail++; $display("FAIL dl_addr: got %0h want 6", mem_addr); end
        @(negedge clk); d_req = 0; #1;
        n_cmp++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL dl_rvalid: got %0h want 1", d_rvalid); end
        n_cmp++; if (d_rdata !== 32'd6000) begin n_fail++; $display("FAIL dl_rdata: got %0d want 6000", d_rdata); end
        n_cmp++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL dl_p_rvalid: got %0h want 0", p_rvalid); end
        n_cmp++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL dl_err: got %0h want 0", d_err); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk); p_req = 1; p_we = 1; p_addr = 1024; p_wdata = 32'hDEAD; #1;
        n_cmp++; if (p_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_gnt: got %0h want 1", p_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_we: got %0h want 0", mem_we); end
        @(negedge clk); p_we = 0; p_addr = 0; #1;
        n_cmp++; if (p_err !== 1'b1) begin n_fail++; $display("FAIL oor_st_err: got %0h want 1", p_err); end
        n_cmp++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL oor_st_rvalid: got %0h want 0", p_rvalid); end
        @(negedge clk); p_addr = 2000; #1;
        n_cmp++; if (p_rvalid !== 1'b1) begin n_fail++; $display("FAIL oor_ld0_rvalid: got %0h want 1", p_rvalid); end
        n_cmp++; if (p_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_ld0_rdata: got %0h want 0", p_rdata); end
        n_cmp++; if (p_err !== 1'b0) begin n_fail++; $display("FAIL oor_ld0_err: got %0h want 0", p_err); end
        @(negedge clk); p_req = 0; #1;
        n_cmp++; if (p_rvalid !== 1'b1) begin n_fail++; $display("FAIL oor_ld_rvalid: got %0h want 1", p_rvalid); end
        n_cmp++; if (p_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_ld_rdata: got %0h want 0", p_rdata); end
        n_cmp++; if (p_err !== 1'b1) begin n_fail++; $display("FAIL oor_ld_err: got %0h want 1", p_err); end
        @(negedge clk); #1;
        n_cmp++; if ({p_err, p_rvalid} !== 2'b00) begin n_fail++; $display("FAIL oor_clear: got %b want 00", {p_err, p_rvalid}); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p_req = 1; p_we = 0; p_addr = 7; d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'hAAAA; #1;
            n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_lose[%0d]: got %0h want 0", i, d_gnt); end
        end
        @(negedge clk); p_req = 0; #1;
        n_cmp++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b want 11", {d_gnt, mem_we}); end
        n_cmp++; if (p_rvalid !== 1'b1 || p_rdata !== 32'd7) begin n_fail++; $display("FAIL rm_pre_rdata: got %0h/%0h want 1/7", p_rvalid, p_rdata); end
        n_cmp++; if (dut.cnt_q !== 4'd3) begin n_fail++; $display("FAIL rm_pre_cnt: got %0d want 3", dut.cnt_q); end
        #1 rst_n = 0; #1;
        n_cmp++; if ({d_gnt, p_gnt, mem_we} !== 3'b000) begin n_fail++; $display("FAIL rm_async_gnt: got %b want 000", {d_gnt, p_gnt, mem_we}); end
        n_cmp++; if ({p_rvalid, d_rvalid, p_err, d_err} !== 4'b0) begin n_fail++; $display("FAIL rm_async_flags: got %b want 0000", {p_rvalid, d_rvalid, p_err, d_err}); end
        n_cmp++; if ({p_rdata, d_rdata} !== 64'd0) begin n_fail++; $display("FAIL rm_async_rdata: got %0h/%0h want 0/0", p_rdata, d_rdata); end
        n_cmp++; if (dut.cnt_q !== 4'd0) begin n_fail++; $display("FAIL rm_async_cnt: got %0d want 0", dut.cnt_q); end
        @(negedge clk); rst_n = 1; idle(); #1;
        n_cmp++; if (mem[3] !== 32'd3) begin n_fail++; $display("FAIL rm_mem3: got %0h want 3", mem[3]); end
        n_cmp++; if (dut.cnt_q !== 4'd0 || dut.state_q !== P_PRIO) begin n_fail++; $display("FAIL rm_post_state: got %0d/%0d want 0/0", dut.cnt_q, dut.state_q); end
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 3; #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_ld_gnt: got %0h want 1", d_gnt); end
        @(negedge clk); d_req = 0; #1;
        n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'd3) begin n_fail++; $display("FAIL rm_ld_rdata: got %0h/%0h want 1/3", d_rvalid, d_rdata); end
    endtask

    task automatic test_alt_d();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            p_req = 0; d_req = (i % 2 == 0); d_we = 0; d_addr = 32'(100 + i); #1;
            n_cmp++; if (d_gnt !== d_req) begin n_fail++; $display("FAIL ad_gnt[%0d]: got %0h want %0h", i, d_gnt, d_req); end
            @(posedge clk); #1;
            n_cmp++; if (dut.cnt_q !== 4'd0) begin n_fail++; $display("FAIL ad_cnt[%0d]: got %0d want 0", i, dut.cnt_q); end
        end
        @(negedge clk); idle();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        clk = 0; rst_n = 0; preload = 1; idle();
        repeat (2) @(posedge clk);
        @(negedge clk); preload = 0;
        test_reset();
        test_p_store_load();
        test_starvation();
        test_d_load();
        test_out_of_range();
        test_reset_mid();
        test_alt_d();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
